mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter_arb_pick.sv | 34 +++
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the two-port memory arbiter: the transaction FSM
// state encoding, the port identifiers used for grants and ack decoding, and
// the default data/address widths.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef logic port_id_t;

    localparam port_id_t PORT_F = 1'b0;
    localparam port_id_t PORT_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Two-way request picker. A lone request wins outright; when both ports
// request, the port named by the pointer wins. Tying the pointer to PORT_D
// gives fixed data-over-fetch priority.
//
// Ports
//   f_req  in   fetch port request
//   d_req  in   data port request
//   ptr    in   port preferred when both request
//   grant  out  winning port ID (meaningful only when a request is present)
// -----------------------------------------------------------------------------
module arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic     f_req,
    input  logic     d_req,
    input  port_id_t ptr,
    output port_id_t grant
);

    // Resolve the winner for the current cycle.
    always_comb begin
        grant = PORT_D;
        if (f_req && d_req) begin
            grant = ptr;
        end else if (f_req) begin
            grant = PORT_F;
        end else begin
            grant = PORT_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one synchronous-read memory between an instruction-fetch port
// (read-only) and a data port (load/store). Each transaction walks
// IDLE -> ACCESS -> RESP -> DONE, so at most one completes every 4 cycles.
// The ack for the served port pulses for the single DONE cycle, with rdata
// already updated for reads.
//
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate contested grants
// (the port not served last wins). Without it, data always beats fetch.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   f_req, f_addr, f_ack  fetch request / address / completion pulse
//   d_req, d_we, d_addr,
//   d_wdata, d_ack        data request / store flag / address / store data /
//                         completion pulse
//   rdata                 last read result, held until the next read completes
//   mem_addr, mem_data,
//   mem_we                memory address / write data / write enable
//   mem_q                 memory read data, valid one cycle after mem_addr
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q
);

    state_t            state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              we_r;
    port_id_t          port_r;

    port_id_t          ptr_s;
    port_id_t          grant_s;
    logic              any_req_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_wdata_s;
    logic              win_we_s;

    assign any_req_s = f_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
    port_id_t ptr_r;
    logic     contest_s;

    assign ptr_s     = ptr_r;
    assign contest_s = f_req & d_req;

    // Point at the loser after every contested grant so it wins the next contest.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= PORT_D;
        end else if ((state_r == IDLE) && contest_s) begin
            ptr_r <= (grant_s == PORT_D) ? PORT_F : PORT_D;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    assign ptr_s = PORT_D;
`endif

    arb_pick u_arb_pick (
        .f_req (f_req),
        .d_req (d_req),
        .ptr   (ptr_s),
        .grant (grant_s)
    );

    // Select the winning port's transaction fields; fetch never writes, so
    // it keeps the current write data to avoid needless toggling.
    always_comb begin
        win_addr_s  = d_addr;
        win_wdata_s = d_wdata;
        win_we_s    = d_we;
        if (grant_s == PORT_F) begin
            win_addr_s  = f_addr;
            win_wdata_s = mem_data;
            win_we_s    = 1'b0;
        end else begin
            win_addr_s  = d_addr;
            win_wdata_s = d_wdata;
            win_we_s    = d_we;
        end
    end

    // Transaction FSM with registered memory drive, read capture and acks.
    // Memory outputs are loaded on the IDLE->ACCESS edge so they are valid
    // throughout ACCESS; mem_we is dropped on the way into RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            addr_r   <= '0;
            wdata_r  <= '0;
            we_r     <= 1'b0;
            port_r   <= PORT_D;
            f_ack    <= 1'b0;
            d_ack    <= 1'b0;
            rdata    <= '0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_we   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    f_ack <= 1'b0;
                    d_ack <= 1'b0;
                    if (any_req_s) begin
                        addr_r   <= win_addr_s;
                        wdata_r  <= win_wdata_s;
                        we_r     <= win_we_s;
                        port_r   <= grant_s;
                        mem_addr <= win_addr_s;
                        mem_data <= win_wdata_s;
                        mem_we   <= win_we_s;
                        state_r  <= ACCESS;
                    end else begin
                        mem_we  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    mem_addr <= addr_r;
                    mem_data <= wdata_r;
                    mem_we   <= 1'b0;
                    state_r  <= RESP;
                end
                RESP: begin
                    if (!we_r) begin
                        rdata <= mem_q;
                    end else begin
                        rdata <= rdata;
                    end
                    f_ack   <= (port_r == PORT_F);
                    d_ack   <= (port_r == PORT_D);
                    mem_we  <= 1'b0;
                    state_r <= DONE;
                end
                DONE: begin
                    f_ack   <= 1'b0;
                    d_ack   <= 1'b0;
                    mem_we  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    f_ack   <= 1'b0;
                    d_ack   <= 1'b0;
                    mem_we  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter with a behavioural 16-word
// synchronous-read, write-through memory (word 0 preloaded with 16'hdead).
// Expected behaviour comes from a transaction-level model: requests are
// scheduled into 4-cycle service slots by the arbitration rules, and a
// reference memory array provides read data.
// Honours ARB_ROUND_ROBIN_EN when defined.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int   DW = 16;
    localparam int   AW = 16;
    localparam logic PF = 1'b0;
    localparam logic PD = 1'b1;

    logic          clk = 1'b0;
    logic          rst;
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_ack;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_we;
    logic [DW-1:0] mem_q;

    logic          preload;
    logic [DW-1:0] mem_arr [0:15];

    int            nchk = 0;
    int            nerr = 0;

    logic [DW-1:0] ref_mem [0:15];
    logic [DW-1:0] ref_rdata;
`ifdef ARB_ROUND_ROBIN_EN
    logic          ref_ptr;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_ack    (f_ack),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .rdata    (rdata),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .mem_q    (mem_q)
    );

    // Memory component: synchronous read, write-through on store.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem_arr[i] <= 16'h1000 + 16'(i);
            mem_arr[0] <= 16'hdead;
            mem_q      <= 16'h0000;
        end else if (mem_we) begin
            mem_arr[mem_addr[3:0]] <= mem_data;
            mem_q                  <= mem_data;
        end else begin
            mem_q <= mem_arr[mem_addr[3:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_f_ack"}, 32'(f_ack), 32'h0);
        chk({tag, "_d_ack"}, 32'(d_ack), 32'h0);
        chk({tag, "_rdata"}, 32'(rdata), 32'h0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
        chk({tag, "_mem_data"}, 32'(mem_data), 32'h0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    endtask

    // One request pattern: schedule it with the model, drive it, and check
    // every cycle until the last slot has finished plus one idle cycle.
    task automatic run_case(input logic f_en, input logic [3:0] fa, input logic d_en,
                            input logic dwe, input logic [3:0] da, input logic [15:0] dwd,
                            input int d_hold);
        logic          s_port [0:7];
        logic          s_we   [0:7];
        logic [3:0]    s_addr [0:7];
        logic [15:0]   s_wd   [0:7];
        logic [15:0]   s_rd   [0:7];
        int            n      = 0;
        logic          f_pend = f_en;
        int            d_left = d_en ? d_hold : 0;
        int            d_seen = 0;
        logic          win;

        while ((f_pend || d_left > 0) && n < 8) begin
            if (f_pend && d_left > 0) begin
`ifdef ARB_ROUND_ROBIN_EN
                win     = ref_ptr;
                ref_ptr = (win == PD) ? PF : PD;
`else
                win = PD;
`endif
            end else begin
                win = f_pend ? PF : PD;
            end
            s_port[n] = win;
            if (win == PF) begin
                f_pend    = 1'b0;
                s_we[n]   = 1'b0;
                s_addr[n] = fa;
            end else begin
                d_left--;
                s_we[n]   = dwe;
                s_addr[n] = da;
            end
            s_wd[n] = dwd;
            if (s_we[n]) ref_mem[s_addr[n]] = dwd;
            else         ref_rdata = ref_mem[s_addr[n]];
            s_rd[n] = ref_rdata;
            n++;
        end

        @(posedge clk);
        #1;
        f_req   = f_en;
        f_addr  = {12'h000, fa};
        d_req   = d_en;
        d_we    = dwe;
        d_addr  = {12'h000, da};
        d_wdata = dwd;

        for (int cyc = 1; cyc <= 4 * n + 1; cyc++) begin
            int   s;
            int   ph;
            logic ef;
            logic ed;
            logic ewe;
            @(posedge clk);
            @(negedge clk);
            s   = (cyc - 1) / 4;
            ph  = (cyc - 1) % 4;
            ef  = 1'b0;
            ed  = 1'b0;
            ewe = 1'b0;
            if (s < n) begin
                if (ph == 0) begin
                    ewe = s_we[s];
                    chk("access_addr", 32'(mem_addr), {28'h0, s_addr[s]});
                    if (s_we[s]) chk("access_data", 32'(mem_data), {16'h0, s_wd[s]});
                end else if (ph == 1) begin
                    chk("resp_addr", 32'(mem_addr), {28'h0, s_addr[s]});
                end else if (ph == 2) begin
                    ef = (s_port[s] == PF);
                    ed = (s_port[s] == PD);
                    chk("ack_rdata", 32'(rdata), {16'h0, s_rd[s]});
                end else begin
                    ef = 1'b0;
                end
            end
            chk("f_ack", 32'(f_ack), 32'(ef));
            chk("d_ack", 32'(d_ack), 32'(ed));
            chk("mem_we", 32'(mem_we), 32'(ewe));
            if (f_ack) f_req = 1'b0;
            if (d_ack) begin
                d_seen++;
                if (d_seen >= d_hold) d_req = 1'b0;
            end
        end
        f_req = 1'b0;
        d_req = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        preload = 1'b1;
        f_req   = 1'b0;
        f_addr  = 16'h0000;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 16'h0000;
        d_wdata = 16'h0000;
        for (int i = 0; i < 16; i++) ref_mem[i] = 16'h1000 + 16'(i);
        ref_mem[0] = 16'hdead;
        ref_rdata  = 16'h0000;
`ifdef ARB_ROUND_ROBIN_EN
        ref_ptr = PD;
`endif

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        rst     = 1'b0;
        preload = 1'b0;

        // Fetch read of the preloaded word
        run_case(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0000, 1);
        chk("fetch_rdata", 32'(rdata), 32'h0000dead);

        // Store then load back
        run_case(1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 16'h0420, 1);
        chk("store_keeps_rdata", 32'(rdata), 32'h0000dead);
        run_case(1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 16'h0000, 1);
        chk("load_rdata", 32'(rdata), 32'h00000420);

        // Contention, twice in a row
        run_case(1'b1, 4'd0, 1'b1, 1'b0, 4'd1, 16'h0000, 1);
        run_case(1'b1, 4'd0, 1'b1, 1'b0, 4'd1, 16'h0000, 1);

        // Data request held through DONE: two separate transactions
        run_case(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 16'h0000, 2);

        // Reset while a store to addr 2 is in ACCESS
        @(posedge clk);
        #1;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0002;
        d_wdata = 16'hbeef;
        @(posedge clk);
        @(negedge clk);
        chk("abort_access_we", 32'(mem_we), 32'h1);
        rst   = 1'b1;
        d_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("abort");
        // mem_we was high at the reset edge, so the memory took the write.
        ref_mem[2] = 16'hbeef;
        ref_rdata  = 16'h0000;
`ifdef ARB_ROUND_ROBIN_EN
        ref_ptr = PD;
`endif
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("abort_no_f_ack", 32'(f_ack), 32'h0);
            chk("abort_no_d_ack", 32'(d_ack), 32'h0);
            chk("abort_no_we", 32'(mem_we), 32'h0);
        end

        // Randomized request patterns
        for (int it = 0; it < 30; it++) begin
            logic f_en;
            logic d_en;
            f_en = 1'($urandom_range(0, 1));
            d_en = 1'($urandom_range(0, 1));
            if (!f_en && !d_en) d_en = 1'b1;
            run_case(f_en, 4'($urandom_range(0, 15)), d_en, 1'($urandom_range(0, 1)),
                     4'($urandom_range(0, 15)), 16'($urandom), int'($urandom_range(1, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
